// File: rtl/rw_arb_pkg.sv
// Shared types and constants for the read/write bus arbiter.
package rw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam int unsigned RSVD_ID = 0;

endpackage

// File: rtl/rw_arb_pick.sv
// Combinational winner select: fixed priority (highest index) by default,
// round-robin from ptr when RW_ARB_ROUND_ROBIN_EN is defined.
module rw_arb_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IdxW-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdxW-1:0]    idx,
  output logic               any
);

`ifdef RW_ARB_ROUND_ROBIN_EN
  always_comb begin
    int cand;
    idx = '0;
    any = |valid;
    // Walk backwards so the candidate closest to ptr is assigned last and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % int'(NUM_REQ);
      if (valid[cand]) idx = IdxW'(cand);
    end
    grant = any ? (NUM_REQ'(1) << idx) : '0;
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    idx = '0;
    any = |valid;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (valid[i]) idx = IdxW'(i);
    end
    grant = any ? (NUM_REQ'(1) << idx) : '0;
  end
`endif

endmodule

// File: rtl/rw_arbiter.sv
// N-requester arbiter onto one read/write master port; latches the granted
// request until completion. RW_ARB_ROUND_ROBIN_EN selects round-robin.
module rw_arbiter
  import rw_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ID_W    = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*2-1:0]        req_size_i,
  input  logic [NUM_REQ-1:0]          req_write_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [DATA_W-1:0]           req_rdata_o,
  output logic                        axi_rw_valid_o,
  input  logic                        axi_rw_ready_i,
  output logic [ID_W-1:0]             axi_rw_id_o,
  output logic [ADDR_W-1:0]           axi_rw_addr_o,
  output logic [1:0]                  axi_rw_size_o,
  output logic                        axi_rw_write_o,
  output logic [DATA_W-1:0]           axi_wt_data_o,
  input  logic [ID_W-1:0]             axi_ret_id_i,
  input  logic [DATA_W-1:0]           axi_ret_rd_data_i,
  output logic                        id_err_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [IdxW-1:0]     gnt_idx_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q, err_d;
  logic                latch_en, done;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_any;
  logic [IdxW-1:0]     ptr;

`ifdef RW_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (done) begin
      ptr_d = (gnt_idx_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign ptr = '0;
`endif

  rw_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_pick (
    .valid (req_valid_i),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    latch_en = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = BUSY;
          latch_en = 1'b1;
        end
      end
      BUSY: begin
        // A completion with someone else's ID is flagged and its data dropped.
        if (axi_rw_ready_i) begin
          if (axi_ret_id_i == id_q) begin
            state_d = RESP;
            done    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (latch_en) begin
        gnt_q     <= pick_grant;
        gnt_idx_q <= pick_idx;
        id_q      <= ID_W'(pick_idx) + ID_W'(1);
        addr_q    <= req_addr_i[pick_idx*ADDR_W +: ADDR_W];
        size_q    <= req_size_i[pick_idx*2 +: 2];
        write_q   <= req_write_i[pick_idx];
        wdata_q   <= req_wdata_i[pick_idx*DATA_W +: DATA_W];
      end
      if (done) rdata_q <= axi_ret_rd_data_i;
    end
  end

  assign axi_rw_valid_o = (state_q == BUSY);
  assign req_ready_o    = (state_q == RESP) ? gnt_q : '0;
  assign req_rdata_o    = (state_q == RESP) ? rdata_q : '0;
  assign axi_rw_id_o    = id_q;
  assign axi_rw_addr_o  = addr_q;
  assign axi_rw_size_o  = size_q;
  assign axi_rw_write_o = write_q;
  assign axi_wt_data_o  = wdata_q;
  assign id_err_o       = err_q;

endmodule

// File: tb/tb_rw_arbiter.sv
// Randomized bench for rw_arbiter (default fixed-priority build) with a
// transaction-level reference model of requesters and the master.
module tb_rw_arbiter;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req_valid_i = '0;
  logic [N-1:0]      req_ready_o;
  logic [N*AW-1:0]   req_addr_i = '0;
  logic [N*2-1:0]    req_size_i = '0;
  logic [N-1:0]      req_write_i = '0;
  logic [N*DW-1:0]   req_wdata_i = '0;
  logic [DW-1:0]     req_rdata_o;
  logic              axi_rw_valid_o;
  logic              axi_rw_ready_i = 1'b0;
  logic [IW-1:0]     axi_rw_id_o;
  logic [AW-1:0]     axi_rw_addr_o;
  logic [1:0]        axi_rw_size_o;
  logic              axi_rw_write_o;
  logic [DW-1:0]     axi_wt_data_o;
  logic [IW-1:0]     axi_ret_id_i = '0;
  logic [DW-1:0]     axi_ret_rd_data_i = '0;
  logic              id_err_o;

  always #5 clock = ~clock;

  rw_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ID_W    (IW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_addr_i        (req_addr_i),
    .req_size_i        (req_size_i),
    .req_write_i       (req_write_i),
    .req_wdata_i       (req_wdata_i),
    .req_rdata_o       (req_rdata_o),
    .axi_rw_valid_o    (axi_rw_valid_o),
    .axi_rw_ready_i    (axi_rw_ready_i),
    .axi_rw_id_o       (axi_rw_id_o),
    .axi_rw_addr_o     (axi_rw_addr_o),
    .axi_rw_size_o     (axi_rw_size_o),
    .axi_rw_write_o    (axi_rw_write_o),
    .axi_wt_data_o     (axi_wt_data_o),
    .axi_ret_id_i      (axi_ret_id_i),
    .axi_ret_rd_data_i (axi_ret_rd_data_i),
    .id_err_o          (id_err_o)
  );

  int total = 0;
  int bad   = 0;

  // Requester-side model: what each requester currently wants.
  logic [N-1:0]  pend = '0;
  logic [AW-1:0] m_addr  [N];
  logic [1:0]    m_size  [N];
  logic          m_write [N];
  logic [DW-1:0] m_wdata [N];
  bit            err_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_reqs();
    req_valid_i = pend;
    for (int i = 0; i < N; i++) begin
      req_addr_i[i*AW +: AW]  = m_addr[i];
      req_size_i[i*2 +: 2]    = m_size[i];
      req_write_i[i]          = m_write[i];
      req_wdata_i[i*DW +: DW] = m_wdata[i];
    end
  endtask

  task automatic new_req(input int i);
    pend[i]    = 1'b1;
    m_addr[i]  = {$urandom, $urandom};
    m_size[i]  = 2'($urandom_range(0, 3));
    m_write[i] = 1'($urandom_range(0, 1));
    m_wdata[i] = {$urandom, $urandom};
  endtask

  // Fixed priority: highest pending index.
  function automatic int top_pick(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check_busy(input int w, input logic [AW-1:0] ea, input logic [1:0] es,
                            input logic ew, input logic [DW-1:0] ed);
    check_eq("busy_valid", 64'(axi_rw_valid_o), 64'd1);
    check_eq("busy_id", 64'(axi_rw_id_o), 64'(w + 1));
    check_eq("busy_addr", axi_rw_addr_o, ea);
    check_eq("busy_size", 64'(axi_rw_size_o), 64'(es));
    check_eq("busy_write", 64'(axi_rw_write_o), 64'(ew));
    check_eq("busy_wdata", axi_wt_data_o, ed);
    check_eq("busy_ready", 64'(req_ready_o), 64'd0);
    check_eq("busy_rdata", req_rdata_o, 64'd0);
    check_eq("busy_err", 64'(id_err_o), 64'(err_exp));
  endtask

  // Entered with the DUT in IDLE for the current cycle; leaves it in IDLE.
  task automatic run_txn(input int delay, input bit bad_id, input logic [DW-1:0] data,
                         input bit arrivals);
    int            w;
    logic [AW-1:0] ea;
    logic [1:0]    es;
    logic          ew;
    logic [DW-1:0] ed;
    logic [N-1:0]  er;
    if (pend == '0) begin
      drive_reqs();
      check_eq("idle_empty_valid", 64'(axi_rw_valid_o), 64'd0);
      step();
      new_req($urandom_range(0, N - 1));
    end
    drive_reqs();
    // Stray completion in IDLE must be ignored.
    if (arrivals && ($urandom_range(0, 3) == 0)) begin
      axi_rw_ready_i = 1'b1;
      axi_ret_id_i   = IW'($urandom);
    end
    check_eq("idle_valid", 64'(axi_rw_valid_o), 64'd0);
    check_eq("idle_ready", 64'(req_ready_o), 64'd0);
    check_eq("idle_rdata", req_rdata_o, 64'd0);
    w  = top_pick(pend);
    ea = m_addr[w];
    es = m_size[w];
    ew = m_write[w];
    ed = m_wdata[w];
    step();
    axi_rw_ready_i = 1'b0;
    check_busy(w, ea, es, ew, ed);
    // Granted fields change; the latched copy must not.
    m_addr[w]  = ~m_addr[w];
    m_size[w]  = ~m_size[w];
    m_write[w] = ~m_write[w];
    m_wdata[w] = ~m_wdata[w];
    if (arrivals) begin
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
    end
    drive_reqs();
    for (int k = 0; k < delay; k++) begin
      step();
      check_busy(w, ea, es, ew, ed);
    end
    if (bad_id) begin
      axi_rw_ready_i    = 1'b1;
      axi_ret_id_i      = IW'((w + 2 + $urandom_range(0, 13)) % 16);
      axi_ret_rd_data_i = {$urandom, $urandom};
      step();
      axi_rw_ready_i = 1'b0;
      err_exp        = 1'b1;
      check_busy(w, ea, es, ew, ed);
    end
    axi_rw_ready_i    = 1'b1;
    axi_ret_id_i      = IW'(w + 1);
    axi_ret_rd_data_i = data;
    step();
    // Completion strobes during RESP must be ignored.
    if ($urandom_range(0, 1) == 1) begin
      axi_ret_id_i      = IW'($urandom);
      axi_ret_rd_data_i = {$urandom, $urandom};
    end else begin
      axi_rw_ready_i = 1'b0;
    end
    er    = '0;
    er[w] = 1'b1;
    check_eq("resp_ready", 64'(req_ready_o), 64'(er));
    check_eq("resp_rdata", req_rdata_o, data);
    check_eq("resp_valid", 64'(axi_rw_valid_o), 64'd0);
    check_eq("resp_err", 64'(id_err_o), 64'(err_exp));
    pend[w] = 1'b0;
    drive_reqs();
    step();
    axi_rw_ready_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_addr[i] = '0; m_size[i] = '0; m_write[i] = 1'b0; m_wdata[i] = '0;
    end
    drive_reqs();
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_valid", 64'(axi_rw_valid_o), 64'd0);
    check_eq("rst_ready", 64'(req_ready_o), 64'd0);
    check_eq("rst_id", 64'(axi_rw_id_o), 64'd0);
    check_eq("rst_addr", axi_rw_addr_o, 64'd0);
    check_eq("rst_rdata", req_rdata_o, 64'd0);
    check_eq("rst_err", 64'(id_err_o), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Single fetch from requester 0.
    new_req(0);
    m_addr[0]  = 64'h8000_0000;
    m_write[0] = 1'b0;
    run_txn(2, 1'b0, 64'h13, 1'b0);

    // Contention: store from requester 1 wins, then requester 0.
    new_req(0);
    new_req(1);
    m_addr[1]  = 64'h8000_1000;
    m_write[1] = 1'b1;
    m_wdata[1] = 64'hDEAD;
    run_txn(1, 1'b0, {$urandom, $urandom}, 1'b0);
    run_txn(0, 1'b0, {$urandom, $urandom}, 1'b0);

    // Wrong ID followed by the correct one.
    new_req(0);
    m_addr[0] = 64'h100;
    run_txn(1, 1'b1, 64'h55AA, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_txn($urandom_range(0, 3), ($urandom_range(0, 7) == 0), {$urandom, $urandom}, 1'b1);
    end

    // Asynchronous reset in the middle of BUSY.
    pend = '0;
    new_req(0);
    drive_reqs();
    step();
    check_eq("pre_rst_valid", 64'(axi_rw_valid_o), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    err_exp = 1'b0;
    check_eq("arst_valid", 64'(axi_rw_valid_o), 64'd0);
    check_eq("arst_ready", 64'(req_ready_o), 64'd0);
    check_eq("arst_err", 64'(id_err_o), 64'd0);
    check_eq("arst_id", 64'(axi_rw_id_o), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    step();
    check_eq("post_rst_valid", 64'(axi_rw_valid_o), 64'd1);
    check_eq("post_rst_id", 64'(axi_rw_id_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
